// File: rtl/parameterized_barrel_unshifter.sv
// Multi-cycle right-rotator: one log-stage per cycle over N cycles, with a
// valid/ready handshake on both sides. Latency is fixed at N regardless of amount.
module parameterized_barrel_unshifter #(
  parameter int N        = 4,
  parameter int NUM_BITS = 2**N
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] in,
  input  logic [N-1:0]        shift_amount,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int STG_W = $clog2(N + 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [STG_W-1:0]    stage_q;
  logic [NUM_BITS-1:0] work_q;
  logic [NUM_BITS-1:0] work_d;
  logic [NUM_BITS-1:0] out_q;
  logic [N-1:0]        amt_q;
  logic [N-1:0]        amt_sh;
  logic                out_valid_q;
  logic                busy_q;

  function automatic logic [NUM_BITS-1:0] rotr(input logic [NUM_BITS-1:0] v,
                                                input int unsigned        a);
    logic [2*NUM_BITS-1:0] d;
    d = {v, v} >> (a % NUM_BITS);
    return d[NUM_BITS-1:0];
  endfunction

  // Stage k rotates by 2**k when bit k of the captured amount is set.
  always_comb begin
    amt_sh = amt_q >> stage_q;
    work_d = amt_sh[0] ? rotr(work_q, 32'd1 << stage_q) : work_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      work_q      <= '0;
      amt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in;
            amt_q   <= shift_amount;
            stage_q <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q  <= work_d;
          stage_q <= stage_q + 1'b1;
          if (stage_q == LAST_STAGE) begin
            out_q       <= work_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_parameterized_barrel_unshifter.sv
// Directed and randomized bench for parameterized_barrel_unshifter against an
// index-based rotate model; checks latency, spacing, backpressure and reset.
module tb_parameterized_barrel_unshifter;
  localparam int N  = 4;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] din;
  logic [N-1:0]  shamt;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] dout;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  parameterized_barrel_unshifter #(.N(N), .NUM_BITS(NB)) dut (
    .clk(clk), .reset(reset), .in(din), .shift_amount(shamt),
    .in_valid(in_valid), .in_ready(in_ready), .out(dout),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] ref_rotr(input logic [NB-1:0] w, input int a);
    logic [NB-1:0] r;
    for (int j = 0; j < NB; j++) r[j] = w[(j + a) % NB];
    return r;
  endfunction

  function automatic logic [NB-1:0] ref_rotl(input logic [NB-1:0] w, input int a);
    logic [NB-1:0] r;
    for (int j = 0; j < NB; j++) r[(j + a) % NB] = w[j];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Counts edges from the accepting edge to out_valid, checking busy on the way.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < N + 6) begin
      check("busy_in_shift", {31'd0, busy}, 32'd1);
      check("in_ready_in_shift", {31'd0, in_ready}, 32'd0);
      tick();
      lat++;
    end
  endtask

  task automatic request(input string tag, input logic [NB-1:0] w, input int a,
                         input logic [NB-1:0] exp);
    int lat;
    din = w; shamt = N'(a); in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_latency"}, lat, N);
    check({tag, "_out"}, {16'd0, dout}, {16'd0, exp});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    tick();
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int prev_acc;
    logic [NB-1:0] held;
    logic [NB-1:0] w;
    reset = 1'b1; din = '0; shamt = '0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out", {16'd0, dout}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    request("r8001_1", 16'h8001, 1, 16'hC000);
    request("r8001_15", 16'h8001, 15, 16'h0003);
    request("r1234_4", 16'h1234, 4, 16'h4123);
    request("r1234_0", 16'h1234, 0, 16'h1234);

    // Backpressure with in_valid pulses during DONE
    din = 16'hA5C3; shamt = 4'd7; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", lat, N);
    held = dout;
    check("bp_out", {16'd0, held}, {16'd0, ref_rotr(16'hA5C3, 7)});
    for (int k = 0; k < 5; k++) begin
      din = 16'(k * 16'h1111); shamt = N'(k); in_valid = k[0];
      tick();
      check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      check("bp_out_hold", {16'd0, dout}, {16'd0, held});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_out_kept", {16'd0, dout}, {16'd0, held});

    // Reset during the second SHIFT cycle
    din = 16'h0F0F; shamt = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_out", {16'd0, dout}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < N + 2; k++) begin
      tick();
      check("mid_rst_no_pulse", {31'd0, out_valid}, 32'd0);
    end
    request("post_rst_req", 16'hBEEF, 9, ref_rotr(16'hBEEF, 9));

    // Back-to-back sweep with in_valid held high; second pass checks composition
    prev_acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      int a;
      logic [NB-1:0] exp;
      a = i % 16;
      if (i < 16) begin
        w = 16'h8001;
        din = w;
        exp = ref_rotr(w, a);
      end else begin
        w = 16'($urandom);
        din = ref_rotl(w, a);
        exp = w;
      end
      shamt = N'(a);
      in_valid = 1'b1;
      check("sweep_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (i > 0) check("sweep_spacing", cyc - prev_acc, N + 2);
      prev_acc = cyc;
      wait_valid(lat);
      check("sweep_latency", lat, N);
      check("sweep_out", {16'd0, dout}, {16'd0, exp});
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("final_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/parameterized_barrel_unshifter.md
PARAMETERIZED_BARREL_UNSHIFTER -- requirements
Module: parameterized_barrel_unshifter

Interface
REQ-001 The block SHALL take parameter N, default 4, which is the shift-amount width in bits.
REQ-002 The block SHALL take parameter NUM_BITS, default 2**N, which is the data word width in bits.
REQ-003 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset.
REQ-005 in  input  NUM_BITS  Data word to rotate.
REQ-006 shift_amount  input  N  Right-rotate distance, 0..NUM_BITS-1.
REQ-007 in_valid  input  1  Request valid.
REQ-008 in_ready  output  1  Block can accept a request.
REQ-009 out  output  NUM_BITS  Rotated result.
REQ-010 out_valid  output  1  The value on out is valid.
REQ-011 out_ready  input  1  The consumer accepts out.
REQ-012 busy  output  1  High in states SHIFT and DONE.

Function
REQ-013 The block SHALL compute out = in rotated right by shift_amount, i.e. out[j] = in[(j + shift_amount) mod NUM_BITS], with no bits lost.
REQ-014 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-015 IDLE: in_ready SHALL be 1 (0 while reset is high); an in_valid&in_ready edge SHALL capture in and shift_amount into registers, clear stage counter to 0, and move to SHIFT.
REQ-016 SHIFT: each cycle, if captured amount bit[stage] is 1 the working register SHALL rotate right by 2**stage, else hold; stage SHALL increment.
REQ-017 SHIFT SHALL last exactly N cycles; after stage N-1 the state SHALL move to DONE.
REQ-018 Latency: out_valid SHALL rise exactly N clock edges after the accepting edge, independent of shift_amount (amount 0 included).
REQ-019 DONE: out_valid SHALL be 1 and out SHALL equal the final working register; on out_valid&out_ready the state SHALL return to IDLE.
REQ-020 With out_ready low in DONE, out and out_valid SHALL hold stable indefinitely.
REQ-021 in_ready SHALL be 0 in SHIFT and DONE; in_valid there SHALL be ignored, and captured operands SHALL not change.
REQ-022 Minimum request spacing SHALL be N+2 cycles: accept, N shift cycles, one DONE cycle with out_ready high, then IDLE.
REQ-023 out SHALL hold the last completed result while not in DONE; out_valid SHALL be 0 outside DONE.
REQ-024 The stage counter SHALL be ceil(log2(N+1)) bits wide at minimum and SHALL not wrap within a request.
REQ-025 Composition: for any word w and amount a, applying this block to a left-rotate-by-a of w SHALL return w.

Reset
REQ-026 While reset is high at a clock edge, the block SHALL go to IDLE, set out=0, out_valid=0, busy=0, stage=0, and clear the working and captured registers to 0.
REQ-027 Reset SHALL take priority over every handshake in the same cycle; a reset in SHIFT or DONE SHALL discard the in-flight request with no out_valid pulse.
REQ-028 in_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.

Verification
REQ-029 in=0x8001, shift_amount=1, out_ready=1 -> out_valid rises 4 edges after accept, out=0xC000, busy high throughout.
REQ-030 in=0x8001, shift_amount=15 -> out=0x0003; in=0x1234, shift_amount=4 -> out=0x4123; shift_amount=0 -> out=0x1234, still 4-cycle latency.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out stable; in_valid pulses are ignored (in_ready=0); release -> IDLE the next cycle.
REQ-032 Reset asserted on the 2nd SHIFT cycle -> next cycle out=0, out_valid=0, busy=0; in_ready=1 after deassert; a new request then completes correctly.
REQ-033 Sweep in=0x8001 and random words with shift_amount 0..15, back-to-back with in_valid held high -> each result matches the reference right-rotate model; the request spacing is exactly N+2 cycles.
